// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises N_SRC request lines, latches them as edge or
// level requests, and presents the lowest-index enabled source through req/ack/eoi.
module irq_ctrl #(
  parameter int               N_SRC       = 18,
  parameter int               ID_W        = 5,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] EDGE_MASK   = {N_SRC{1'b1}},
  parameter logic [N_SRC-1:0] MASK_RST    = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             glob_ie,
  input  logic [N_SRC-1:0] in_intp,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] synced, sync_prev, rise;
  logic [N_SRC-1:0] id_sel, clr, pending_nxt, q;
  logic [ID_W-1:0]  winner;
  logic             q_any, id_enabled, ack_take, load_id;

  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= in_intp;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~sync_prev;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    id_sel = '0;
    for (int i = 0; i < N_SRC; i++) id_sel[i] = (irq_id == ID_W'(i));
  end

  assign ack_take   = (state == S_REQ) && irq_ack;
  assign clr        = ack_take ? (id_sel & EDGE_MASK) : '0;
  // A new edge in the clearing cycle wins over the acknowledge clear.
  assign pending_nxt = (EDGE_MASK & ((pending & ~clr) | rise)) | (~EDGE_MASK & synced);
  assign q          = glob_ie ? (pending & mask) : '0;
  assign q_any      = |q;
  assign id_enabled = |(id_sel & mask);

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (q[i]) winner = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      pending <= pending_nxt;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // State register; the request index is captured when leaving IDLE.
  assign load_id = (state == S_IDLE) && q_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      irq_id <= '0;
    end else begin
      state <= state_nxt;
      if (load_id) irq_id <= winner;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (q_any) state_nxt = S_REQ;
      S_REQ: begin
        if (irq_ack)                      state_nxt = S_SERVICE;
        else if (!glob_ie || !id_enabled) state_nxt = S_IDLE;
      end
      S_SERVICE: if (eoi) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    irq        = (state == S_REQ);
    in_service = (state == S_SERVICE);
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a history-based model.
module tb_irq_ctrl;

  localparam int          N    = 18;
  localparam int          IDW  = 5;
  localparam int          S    = 2;
  localparam logic [N-1:0] EDGE = 18'h3FFEF;
  localparam logic [N-1:0] MRST = 18'h3FFFF;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           glob_ie = 1'b0;
  logic [N-1:0]   in_intp = '0;
  logic           mask_we = 1'b0;
  logic [N-1:0]   mask_wdata = '0;
  logic           irq_ack = 1'b0;
  logic           eoi = 1'b0;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic           in_service;
  logic [N-1:0]   pending;
  logic [N-1:0]   mask;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(
    .N_SRC(N), .ID_W(IDW), .SYNC_STAGES(S), .EDGE_MASK(EDGE), .MASK_RST(MRST)
  ) dut (
    .clk(clk), .rst(rst), .glob_ie(glob_ie), .in_intp(in_intp),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eoi(eoi),
    .irq(irq), .irq_id(irq_id), .in_service(in_service),
    .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // smp[k] holds the raw line value sampled k+1 edges ago.
  logic [N-1:0]   smp [S+1];
  logic [N-1:0]   m_pend, m_mask, m_q, m_next;
  logic [IDW-1:0] m_id;
  bit             m_req, m_serv;
  bit             m_vis;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = '0; m_mask = MRST; m_id = '0; m_req = 0; m_serv = 0;
      for (int k = 0; k <= S; k++) smp[k] = '0;
    end else begin
      m_q = glob_ie ? (m_pend & m_mask) : '0;
      for (int i = 0; i < N; i++) begin
        if (EDGE[i]) begin
          if (smp[S-1][i] && !smp[S][i])                          m_next[i] = 1'b1;
          else if (m_req && irq_ack && (int'(m_id) == i))         m_next[i] = 1'b0;
          else                                                    m_next[i] = m_pend[i];
        end else begin
          m_next[i] = smp[S-1][i];
        end
      end
      if (m_req) begin
        if (irq_ack) begin m_req = 0; m_serv = 1; end
        else if (!glob_ie || !m_mask[m_id]) m_req = 0;
      end else if (m_serv) begin
        if (eoi) m_serv = 0;
      end else if (m_q != '0) begin
        m_req = 1;
        m_id  = IDW'(lowest(m_q));
      end
      if (mask_we) m_mask = mask_wdata;
      m_pend = m_next;
      for (int k = S; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = in_intp;
    end
  end

  always @(negedge clk) begin
    check("m_irq", 32'(irq), 32'(m_req));
    check("m_in_service", 32'(in_service), 32'(m_serv));
    check("m_pending", 32'(pending), 32'(m_pend));
    check("m_mask", 32'(mask), 32'(m_mask));
    if (m_req) check("m_irq_id", 32'(irq_id), 32'(m_id));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic ie);
    rst = 1'b0; glob_ie = ie; in_intp = '0; mask_we = 1'b0;
    irq_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wait_irq(input int max_cycles);
    int c = 0;
    while (!irq && c < max_cycles) begin
      tick();
      c++;
    end
    check("wait_irq", 32'(irq), 32'd1);
  endtask

  task automatic pulse_ack_eoi(input logic a, input logic e);
    irq_ack = a; eoi = e;
    tick();
    irq_ack = 1'b0; eoi = 1'b0;
  endtask

  initial begin
    int lat;

    // Reset defaults and first-request latency.
    rst = 1'b0; glob_ie = 1'b1; in_intp = 18'h3FFFF;
    tick(); tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_mask", 32'(mask), 32'h3FFFF);
    rst = 1'b1;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (irq && lat == 0) lat = c;
    end
    check("rst_latency", 32'(lat), 32'd4);

    // Priority and sequencing.
    do_reset(1'b1);
    in_intp = 18'd5;
    wait_irq(8);
    check("prio_id0", 32'(irq_id), 32'd0);
    pulse_ack_eoi(1'b1, 1'b0);
    check("prio_pend_after_ack", 32'(pending), 32'd4);
    check("prio_in_service", 32'(in_service), 32'd1);
    pulse_ack_eoi(1'b0, 1'b1);
    check("prio_idle_after_eoi", 32'(in_service), 32'd0);
    tick();
    check("prio_irq2", 32'(irq), 32'd1);
    check("prio_id2", 32'(irq_id), 32'd2);
    pulse_ack_eoi(1'b1, 1'b1);
    check("prio_ack_wins", 32'(in_service), 32'd1);
    check("prio_pend_zero", 32'(pending), 32'd0);
    pulse_ack_eoi(1'b0, 1'b1);
    tick();
    check("prio_final_idle", 32'(irq | in_service), 32'd0);

    // Global enable gating.
    do_reset(1'b0);
    in_intp = 18'h80;
    tick();
    in_intp = '0;
    repeat (4) tick();
    check("gie_pend7", 32'(pending[7]), 32'd1);
    check("gie_no_irq", 32'(irq), 32'd0);
    glob_ie = 1'b1;
    tick();
    check("gie_irq", 32'(irq), 32'd1);
    check("gie_id7", 32'(irq_id), 32'd7);

    // Withdraw while requesting.
    do_reset(1'b1);
    in_intp = 18'h8;
    tick();
    in_intp = '0;
    wait_irq(8);
    check("wd_id3", 32'(irq_id), 32'd3);
    glob_ie = 1'b0;
    tick();
    check("wd_irq_drop", 32'(irq), 32'd0);
    check("wd_pend3", 32'(pending[3]), 32'd1);
    glob_ie = 1'b1;
    tick();
    check("wd_irq_back", 32'(irq), 32'd1);
    check("wd_id3_back", 32'(irq_id), 32'd3);

    // Mask and level mode on source 4.
    do_reset(1'b1);
    mask_we = 1'b1; mask_wdata = 18'h3FFEF;
    tick();
    mask_we = 1'b0;
    check("lvl_mask_written", 32'(mask), 32'h3FFEF);
    in_intp = 18'h10;
    repeat (4) tick();
    check("lvl_pend4", 32'(pending[4]), 32'd1);
    check("lvl_masked_no_irq", 32'(irq), 32'd0);
    mask_we = 1'b1; mask_wdata = 18'h3FFFF;
    tick();
    mask_we = 1'b0;
    wait_irq(4);
    check("lvl_id4", 32'(irq_id), 32'd4);
    pulse_ack_eoi(1'b1, 1'b0);
    check("lvl_pend_kept", 32'(pending[4]), 32'd1);
    in_intp = '0;
    repeat (3) tick();
    check("lvl_pend_dropped", 32'(pending[4]), 32'd0);
    pulse_ack_eoi(1'b0, 1'b1);
    tick();
    check("lvl_idle", 32'(irq | in_service), 32'd0);

    // Set/clear collision on an edge source.
    do_reset(1'b1);
    in_intp = 18'h2;
    tick();
    in_intp = '0;
    wait_irq(8);
    check("col_id1", 32'(irq_id), 32'd1);
    in_intp = 18'h2;
    tick();
    in_intp = '0;
    tick();
    pulse_ack_eoi(1'b1, 1'b0);
    check("col_set_wins", 32'(pending[1]), 32'd1);
    check("col_in_service", 32'(in_service), 32'd1);

    // Spurious handshake in IDLE.
    do_reset(1'b1);
    repeat (3) tick();
    pulse_ack_eoi(1'b1, 1'b1);
    check("spur_irq", 32'(irq), 32'd0);
    check("spur_in_service", 32'(in_service), 32'd0);
    tick();
    check("spur_still_idle", 32'(irq | in_service), 32'd0);

    // Randomized traffic against the model.
    do_reset(1'b1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) glob_ie = ~glob_ie;
      if ($urandom_range(0, 15) == 0) in_intp = '0;
      else if ($urandom_range(0, 3) == 0) in_intp = in_intp ^ (N'(1) << $urandom_range(0, N-1));
      mask_we = ($urandom_range(0, 29) == 0);
      mask_wdata = N'($urandom) | N'($urandom);
      irq_ack = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
      eoi     = (m_serv && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
